// File: rtl/down_timer_pkg.sv
// Shared types and default widths for the down_timer block.
package down_timer_pkg;
  localparam int N_DEF     = 12;
  localparam int PRE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;
endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a controller (master) and the down_timer (slave).
interface down_timer_if #(
  parameter int N     = 12,
  parameter int PRE_W = 8
);
  logic             start;
  logic [N-1:0]     load_val;
  logic [PRE_W-1:0] prescale;
  logic             auto_reload;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             paused;
  logic             done;
  logic [N-1:0]     cnt_out;

  modport master (
    output start, load_val, prescale, auto_reload, pause, abort,
    input  busy, paused, done, cnt_out
  );
  modport slave (
    input  start, load_val, prescale, auto_reload, pause, abort,
    output busy, paused, done, cnt_out
  );
endinterface

// File: rtl/down_timer_tick_gen.sv
// Prescaler: latches the period on clear and fires one tick every (period+1) enabled cycles.
module tick_gen #(
  parameter int PRE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [PRE_W-1:0] i_period,
  output logic             o_tick
);
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] r_period;
  logic             w_hit;

  assign w_hit  = (r_pre == r_period);
  assign o_tick = i_en & w_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre    <= '0;
      r_period <= '0;
    end else if (i_clr) begin
      r_pre    <= '0;
      r_period <= i_period;
    end else if (i_en) begin
      r_pre <= w_hit ? '0 : r_pre + 1'b1;
    end
  end
endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer: FSM, count/reload registers and registered done pulse.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  down_timer_if.slave  io
);
  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_cnt, w_cnt_nxt;
  logic [N-1:0]   r_reload;
  logic           r_done, w_done_nxt;
  logic           w_active, w_en, w_load, w_tick;

  assign w_active = (r_state != IDLE);
  // abort masks the prescaler so a cancelled run can never tick on its way out
  assign w_en     = w_active & ~io.pause & ~io.abort;
  assign w_load   = (r_state == IDLE) & io.start & ~io.abort;

  tick_gen #(.PRE_W(PRE_W)) u_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_en),
    .i_clr    (w_load),
    .i_period (io.prescale),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = io.load_val;
        end
      end
      RUN, PAUSE: begin
        if (io.abort) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = io.pause ? PAUSE : RUN;
          if (w_tick) begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - 1'b1;
            end else begin
              w_done_nxt = 1'b1;
              if (io.auto_reload) begin
                w_cnt_nxt = r_reload;
              end else begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
              end
            end
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      if (w_load) r_reload <= io.load_val;
    end
  end

  assign io.busy    = w_active;
  assign io.paused  = (r_state == PAUSE);
  assign io.done    = r_done;
  assign io.cnt_out = r_cnt;
endmodule
